// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: single-word request/acknowledge bus between one master and the SRAM arbiter
interface ram_arbiter_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [1:0]  be;
  logic        ack;
  logic [15:0] rdata;
  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter/sequencer for the SRAM MAR/MDR register block, with read-modify-write for partial writes.
// Define RAM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module ram_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  ram_arbiter_if.slave p0,
  ram_arbiter_if.slave p1,
  output logic        reg_load_ub,
  output logic        reg_load_lb,
  output logic        reg_sel,
  output logic        read,
  output logic        write,
  output logic [15:0] reg_d,
  input  logic [15:0] reg_q
);
  typedef enum logic [2:0] {IDLE, ADDR, READ, DATA, WRITE, CAPT, DONE} state_t;
  state_t      state, nxt;
  logic        sel, port, pn, last, we, w_we;
  logic [1:0]  be, w_be;
  logic [15:0] addr, wdata, w_addr, w_wdata;
  logic [3:0]  cnt;
  logic        ld_ub_n, ld_lb_n, sel_n, read_n, write_n, ack_n;
  logic [15:0] reg_d_n;
`ifdef RAM_ARB_FIXED_PRIO_EN
  assign sel = ~p0.req;
`else
  logic ptr;
  assign sel = (p0.req & p1.req) ? ptr : p1.req;
  always_ff @(posedge clock or posedge reset)
    if (reset) ptr <= 1'b0;
    else if (ack_n) ptr <= ~pn;
`endif
  assign w_we    = sel ? p1.we : p0.we;
  assign w_be    = sel ? p1.be : p0.be;
  assign w_addr  = sel ? p1.addr : p0.addr;
  assign w_wdata = sel ? p1.wdata : p0.wdata;
  assign pn      = (state == IDLE) ? sel : port;
  assign last    = cnt == 4'(WAIT_CYCLES - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      port        <= 1'b0;
      we          <= 1'b0;
      be          <= '0;
      addr        <= '0;
      wdata       <= '0;
      reg_load_ub <= 1'b0;
      reg_load_lb <= 1'b0;
      reg_sel     <= 1'b0;
      read        <= 1'b0;
      write       <= 1'b0;
      reg_d       <= '0;
      p0.ack      <= 1'b0;
      p1.ack      <= 1'b0;
      p0.rdata    <= '0;
      p1.rdata    <= '0;
    end else begin
      state       <= nxt;
      cnt         <= (nxt == state && (state == READ || state == WRITE)) ? cnt + 4'd1 : '0;
      if (state == IDLE) begin
        port  <= sel;
        we    <= w_we;
        be    <= w_be;
        addr  <= w_addr;
        wdata <= w_wdata;
      end
      reg_load_ub <= ld_ub_n;
      reg_load_lb <= ld_lb_n;
      reg_sel     <= sel_n;
      read        <= read_n;
      write       <= write_n;
      reg_d       <= reg_d_n;
      p0.ack      <= ack_n & ~pn;
      p1.ack      <= ack_n & pn;
      if (state == CAPT && !port) p0.rdata <= reg_q;
      if (state == CAPT && port) p1.rdata <= reg_q;
    end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (p0.req | p1.req) nxt = (w_we && w_be == 2'b00) ? DONE : ADDR;
      ADDR:    nxt = (we && be == 2'b11) ? DATA : READ;
      READ:    if (last) nxt = we ? DATA : CAPT;
      DATA:    nxt = WRITE;
      WRITE:   if (last) nxt = DONE;
      CAPT:    nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  // outputs are decoded from the next state so every strobe leaves a flop
  always_comb begin
    sel_n   = nxt == ADDR;
    ld_ub_n = (nxt == ADDR) | ((nxt == DATA) & be[1]);
    ld_lb_n = (nxt == ADDR) | ((nxt == DATA) & be[0]);
    read_n  = nxt == READ;
    write_n = nxt == WRITE;
    ack_n   = nxt == DONE;
    reg_d_n = (nxt == ADDR) ? w_addr : (nxt == DATA) ? wdata : 16'h0000;
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter against a behavioural MAR/MDR SRAM block model.
module tb_ram_arbiter;
`ifdef RAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  ram_arbiter_if a0 (), a1 (), b0 (), b1 ();
  logic        ld_ub, ld_lb, sel, rd, wr, ld_ub3, ld_lb3, sel3, rd3, wr3;
  logic [15:0] d, q, d3, q3, mar1, mdr1, mar3, mdr3;
  logic [15:0] mem1 [256];
  logic [15:0] mem3 [256];
  int vec = 0, errs = 0, cyc = 0, nrd3 = 0;
  ram_arbiter #(.WAIT_CYCLES(1)) u1 (.clock(clock), .reset(reset), .p0(a0), .p1(a1),
    .reg_load_ub(ld_ub), .reg_load_lb(ld_lb), .reg_sel(sel), .read(rd), .write(wr), .reg_d(d), .reg_q(q));
  ram_arbiter #(.WAIT_CYCLES(3)) u3 (.clock(clock), .reset(reset), .p0(b0), .p1(b1),
    .reg_load_ub(ld_ub3), .reg_load_lb(ld_lb3), .reg_sel(sel3), .read(rd3), .write(wr3), .reg_d(d3), .reg_q(q3));
  always @(posedge clock) begin
    if (ld_ub) begin if (sel) mar1[15:8] <= d[15:8]; else mdr1[15:8] <= d[15:8]; end
    if (ld_lb) begin if (sel) mar1[7:0] <= d[7:0]; else mdr1[7:0] <= d[7:0]; end
    if (rd) mdr1 <= mem1[mar1[7:0]];
    if (wr) mem1[mar1[7:0]] <= mdr1;
  end
  assign q = sel ? mar1 : mdr1;
  always @(posedge clock) begin
    if (ld_ub3) begin if (sel3) mar3[15:8] <= d3[15:8]; else mdr3[15:8] <= d3[15:8]; end
    if (ld_lb3) begin if (sel3) mar3[7:0] <= d3[7:0]; else mdr3[7:0] <= d3[7:0]; end
    if (rd3) mdr3 <= mem3[mar3[7:0]];
    if (wr3) mem3[mar3[7:0]] <= mdr3;
  end
  assign q3 = sel3 ? mar3 : mdr3;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    nrd3 += int'(rd3);
    chk("exclusive", {rd & wr, a0.ack & a1.ack, (rd | wr) & (ld_ub | ld_lb), rd3 & wr3, (rd3 | wr3) & (ld_ub3 | ld_lb3)}, 0);
  endtask
  task automatic start(input int p, input logic we, input logic [15:0] ad, input logic [15:0] wd, input logic [1:0] be);
    step();
    case (p)
      0:       begin a0.we = we; a0.addr = ad; a0.wdata = wd; a0.be = be; a0.req = 1'b1; end
      1:       begin a1.we = we; a1.addr = ad; a1.wdata = wd; a1.be = be; a1.req = 1'b1; end
      default: begin b0.we = we; b0.addr = ad; b0.wdata = wd; b0.be = be; b0.req = 1'b1; end
    endcase
    cyc = 0;
    nrd3 = 0;
  endtask
  function automatic logic ack_of(input int p);
    return p == 0 ? a0.ack : p == 1 ? a1.ack : b0.ack;
  endfunction
  task automatic drop(input int p);
    if (p == 0) a0.req = 1'b0;
    else if (p == 1) a1.req = 1'b0;
    else b0.req = 1'b0;
  endtask
  task automatic wait_ack(input int p, input int exp, input string tag);
    do step(); while (!ack_of(p) && cyc < 40);
    chk(tag, cyc, exp);
    drop(p);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    a0.req = 0; a0.we = 0; a0.addr = 0; a0.wdata = 0; a0.be = 0;
    a1.req = 0; a1.we = 0; a1.addr = 0; a1.wdata = 0; a1.be = 0;
    b0.req = 0; b0.we = 0; b0.addr = 0; b0.wdata = 0; b0.be = 0;
    b1.req = 0; b1.we = 0; b1.addr = 0; b1.wdata = 0; b1.be = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_out", {ld_ub, ld_lb, sel, rd, wr, d, a0.ack, a1.ack}, 0);
    chk("reset_rdata", {a0.rdata, a1.rdata, b0.rdata}, 0);
    reset = 1'b0;
    step();
    a0.we = 1; a0.addr = 16'h0040; a0.wdata = 16'h1111; a0.be = 2'b11; a0.req = 1;
    a1.we = 1; a1.addr = 16'h0041; a1.wdata = 16'h2222; a1.be = 2'b11; a1.req = 1;
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      do step(); while (!(a0.ack | a1.ack) && cyc < 40);
      chk("rr_timeout", cyc < 40, 1);
      chk("rr_port", a1.ack, FIXED ? 0 : k % 2);
    end
    a0.req = 0;
    a1.req = 0;
    start(0, 1, 16'h0012, 16'hBEEF, 2'b11);
    step();
    chk("fw_addr", {sel, ld_ub, ld_lb, rd, wr, d}, {5'b11100, 16'h0012});
    step();
    chk("fw_data", {sel, ld_ub, ld_lb, rd, wr, d}, {5'b01100, 16'hBEEF});
    step();
    chk("fw_write", {wr, rd, ld_ub, ld_lb, a0.ack, d}, {5'b10000, 16'h0000});
    step();
    chk("fw_ack", {a0.ack, a1.ack, wr}, 3'b100);
    drop(0);
    start(0, 0, 16'h0012, 16'h0000, 2'b11);
    wait_ack(0, 4, "rd_latency");
    chk("rd_data", a0.rdata, 16'hBEEF);
    start(0, 1, 16'h0020, 16'h1234, 2'b11);
    wait_ack(0, 4, "pw_pre_latency");
    start(0, 1, 16'h0020, 16'h55AA, 2'b10);
    step();
    chk("pw_addr", {sel, d}, {1'b1, 16'h0020});
    step();
    chk("pw_read", {rd, wr, ld_ub, ld_lb}, 4'b1000);
    step();
    chk("pw_data", {sel, ld_ub, ld_lb, rd, d}, {4'b0100, 16'h55AA});
    wait_ack(0, 5, "pw_latency");
    start(1, 0, 16'h0020, 16'h0000, 2'b11);
    wait_ack(1, 4, "pw_rd1_latency");
    chk("pw_rdata1", a1.rdata, 16'h5534);
    start(1, 1, 16'h0020, 16'hFFFF, 2'b00);
    step();
    chk("be0_ack", {a1.ack, a0.ack, sel, ld_ub, ld_lb, rd, wr}, 7'b1000000);
    drop(1);
    start(0, 0, 16'h0020, 16'h0000, 2'b11);
    wait_ack(0, 4, "be0_rd_latency");
    chk("be0_unchanged", a0.rdata, 16'h5534);
    start(1, 1, 16'h0060, 16'h7777, 2'b11);
    repeat (3) step();
    chk("rst_pre_write", wr, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_drop", {wr, rd, ld_ub, ld_lb, sel, a1.ack}, 0);
    step();
    chk("rst_no_ack", a1.ack, 0);
    reset = 1'b0;
    cyc = 0;
    wait_ack(1, 4, "rst_restart_latency");
    step();
    step();
    chk("rst_single_ack", {a1.ack, a0.ack}, 0);
    start(2, 1, 16'h0005, 16'h0ACE, 2'b11);
    wait_ack(2, 6, "w3_write_latency");
    start(2, 0, 16'h0005, 16'h0000, 2'b11);
    wait_ack(2, 6, "w3_read_latency");
    chk("w3_read_len", nrd3, 3);
    chk("w3_rdata", b0.rdata, 16'h0ACE);
    start(2, 1, 16'h0006, 16'h0BBB, 2'b11);
    wait_ack(2, 6, "w3_write2_latency");
    chk("w3_rdata_held", b0.rdata, 16'h0ACE);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port arbiter and sequencer for the SRAM register interface block (MAR/MDR pair, byte-lane register loads, read/write strobes).
- Converts single-word requests from two masters (port 0 = CPU, port 1 = DMA/video) into the exact register-load and strobe sequence the SRAM block needs.
- Performs read-modify-write for partial-byte writes, because the SRAM byte enables are held permanently active.
- Round-robin between the two ports; a grant is held until that port is acknowledged.

Parameters:
WAIT_CYCLES, 1, cycles read or write is held asserted per SRAM access; legal 1..15; 4-bit counter.

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req0  in  1  port 0 request; held high until ack0
we0  in  1  port 0 write (1) / read (0); stable while req0 high
addr0  in  16  port 0 word address
wdata0  in  16  port 0 write data
be0  in  2  port 0 byte enables {ub,lb}
ack0  out  1  one-cycle completion pulse
rdata0  out  16  port 0 read data; valid with ack0, held until next port-0 read ack
req1, we1, addr1, wdata1, be1, ack1, rdata1  same as port 0, for port 1
reg_load_ub  out  1  to SRAM block: upper-byte register load
reg_load_lb  out  1  to SRAM block: lower-byte register load
reg_sel  out  1  to SRAM block: 1 = MAR, 0 = MDR
read  out  1  to SRAM block: read strobe (MDR loads from SRAM data)
write  out  1  to SRAM block: write strobe
reg_d  out  16  to SRAM block: register write data
reg_q  in  16  from SRAM block: selected register contents

Behaviour:
- Reset values: state IDLE; all strobes and reg_load_* 0; reg_sel 0; reg_d 0; ack0/ack1 0; rdata0/rdata1 0; round-robin pointer = port 0; wait counter 0.
- Reset asserted mid-operation: return to IDLE immediately; strobes drop asynchronously; no ack issued; a request still held is re-arbitrated after reset is released.
- All outputs are registered (Moore FSM). reg_d = 0 outside ADDR and DATA.
- Arbitration in IDLE:
  - Only one request high: that port wins.
  - Both high: pointer port wins; the pointer moves to the other port when the winner's ack is issued.
  - Address, data, be and we of the winner are latched at grant.
- States and outputs:
  - IDLE: no outputs active.
  - ADDR (1 cycle): reg_sel=1, reg_load_ub=reg_load_lb=1, reg_d=addr.
  - READ (WAIT_CYCLES cycles): read=1, reg_sel=0, no reg loads.
  - DATA (1 cycle): reg_sel=0, reg_load_ub=be[1], reg_load_lb=be[0], reg_d=wdata. On a partial write, the SRAM block merges with the MDR contents just read.
  - WRITE (WAIT_CYCLES cycles): write=1, reg_sel=0, no reg loads.
  - CAPT (1 cycle): reg_sel=0; rdataN <= reg_q at end of cycle.
  - DONE (1 cycle): ackN=1; then IDLE. No back-to-back grant out of DONE.
- Sequences:
  - Read: ADDR, READ, CAPT, DONE.
  - Full write (be=11): ADDR, DATA, WRITE, DONE.
  - Partial write (be=01 or 10): ADDR, READ, DATA, WRITE, DONE.
  - be=00 write: IDLE then DONE; no SRAM activity, ack only.
- Latency, counting the cycle req is sampled in IDLE as cycle 0:
  - Read or full write: ack in cycle 3+W.
  - Partial write: ack in cycle 3+2W.
  - be=00 write: ack in cycle 1.
  - W = WAIT_CYCLES.
- Simultaneous events:
  - A request arriving while busy waits; requests are never dropped.
  - Lowering req before ack is illegal; the transaction still completes and acks.
  - ack0 and ack1 are never high together.
- read and write are never high together; reg_load_* are never high while read or write is high.

Optional Feature:
- Macro: RAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; port 0 always wins a simultaneous request; the round-robin pointer is removed.
- Undefined: round-robin as specified above.

Test Plan:
- WAIT_CYCLES=1, port 0 full write addr=0x0012, wdata=0xBEEF, be=11 -> ADDR cycle 1 with reg_sel=1 and reg_d=0x0012; DATA cycle 2; write high in cycle 3; ack0 in cycle 4. A following read of 0x0012 -> rdata0=0xBEEF with ack0.
- Partial write be=10, wdata=0x55AA, over stored 0x1234 -> READ precedes DATA; DATA has reg_load_ub=1 and reg_load_lb=0; read-back gives 0x5534; ack at cycle 3+2W.
- req0 and req1 rise in the same cycle, both held for 4 transactions -> grants alternate 0,1,0,1. With RAM_ARB_FIXED_PRIO_EN defined, port 0 wins every simultaneous conflict.
- WAIT_CYCLES=3 read -> read held exactly 3 cycles; ack at cycle 6; rdata stable until the next read ack on that port.
- Write with be=00 -> ack in cycle 1; write, read and reg_load_* never asserted.
- reset pulsed during WRITE with req1 held -> write drops immediately; no ack1; after release the full sequence restarts and ack1 is issued once.
